// File: rtl/an37_sys_frame_sched.sv
// ---------------------------------------------------------------------------
// an37_sys_frame_sched
//
// Frame scheduler for the 6x6 systolic AN-code (A=37) Barrett decoder array.
// Collects a valid/ready stream of coded words into an N_WORDS-slot frame,
// presents the whole frame to the array with a one-cycle start pulse, waits
// out the array latency, then streams the decoded words back out in slot
// order. Each decoded word is re-encoded (out*A) and compared with the
// original coded word so that uncorrectable/invalid codes are flagged.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   s_valid    input word valid
//   s_ready    scheduler accepts an input word (IDLE/FILL only)
//   s_data     coded input word (IN_W bits)
//   s_last     closes the current frame early on accept
//   arr_in     frame to the array, slot i at [i*IN_W +: IN_W]
//   arr_start  one-cycle pulse, arr_in frame is valid
//   arr_out    decoded words from the array, slot i at [i*OUT_W +: OUT_W]
//   m_valid    decoded word valid
//   m_ready    consumer accepts decoded word
//   m_data     decoded word (OUT_W bits)
//   m_err      decoded word failed the check m_data*A == slot input
//   m_last     last decoded word of the frame
//   err_cnt    saturating count of transferred words with m_err=1
//   busy       scheduler is not idle
// ---------------------------------------------------------------------------
module an37_sys_frame_sched #(
  parameter int N_WORDS = 36,
  parameter int IN_W    = 18,
  parameter int OUT_W   = 13,
  parameter int A       = 37,
  parameter int ARR_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [IN_W-1:0]          s_data,
  input  logic                     s_last,
  output logic [N_WORDS*IN_W-1:0]  arr_in,
  output logic                     arr_start,
  input  logic [N_WORDS*OUT_W-1:0] arr_out,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OUT_W-1:0]         m_data,
  output logic                     m_err,
  output logic                     m_last,
  output logic [15:0]              err_cnt,
  output logic                     busy
);

  localparam int CW       = $clog2(N_WORDS + 1);
  localparam int PW       = IN_W + 1;
  localparam int WAIT_CYC = ARR_LAT - 1;
  localparam int WW       = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  localparam logic [CW-1:0] LAST_SLOT = CW'(N_WORDS - 1);
  localparam logic [WW-1:0] WAIT_END  = WW'(WAIT_CYC - 1);
  localparam logic [PW-1:0] A_EXT     = PW'(A);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_FIRE,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [CW-1:0]             nvalid_q, nvalid_d;
  logic [CW-1:0]             idx_q, idx_d;
  logic [WW-1:0]             wait_q, wait_d;
  logic [N_WORDS*IN_W-1:0]   arr_in_q, arr_in_d;
  logic [15:0]               err_cnt_q, err_cnt_d;

  logic                      accept;
  logic                      close;
  logic                      xfer;
  logic [OUT_W-1:0]          sel_out;
  logic [IN_W-1:0]           sel_in;
  logic [PW-1:0]             reenc;

  // Slot currently being drained: decoded value from the array and the
  // original coded word it came from.
  assign sel_out = arr_out[idx_q*OUT_W +: OUT_W];
  assign sel_in  = arr_in_q[idx_q*IN_W +: IN_W];

  // Re-encode at IN_W+1 bits so an out-of-range decode cannot alias back
  // onto a valid codeword through truncation.
  assign reenc = PW'(sel_out) * A_EXT;

  assign s_ready = (state_q == S_IDLE) || (state_q == S_FILL);
  assign accept  = s_valid && s_ready;
  assign close   = accept && (s_last || (cnt_q == LAST_SLOT));
  assign xfer    = (state_q == S_DRAIN) && m_ready;

  // Next-state and datapath control. The frame buffer is cleared when the
  // last word drains so that any slot not written by the next frame is 0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nvalid_d = nvalid_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    arr_in_d = arr_in_q;

    unique case (state_q)
      S_IDLE, S_FILL: begin
        if (accept) begin
          arr_in_d[cnt_q*IN_W +: IN_W] = s_data;
          cnt_d = cnt_q + CW'(1);
          if (close) begin
            nvalid_d = cnt_q + CW'(1);
            state_d  = S_FIRE;
          end else begin
            state_d  = S_FILL;
          end
        end
      end

      S_FIRE: begin
        wait_d = '0;
        if (WAIT_CYC == 0) state_d = S_DRAIN;
        else               state_d = S_WAIT;
      end

      S_WAIT: begin
        wait_d = wait_q + WW'(1);
        if (wait_q == WAIT_END) state_d = S_DRAIN;
      end

      S_DRAIN: begin
        if (xfer) begin
          if (idx_q == nvalid_q - CW'(1)) begin
            idx_d    = '0;
            cnt_d    = '0;
            arr_in_d = '0;
            state_d  = S_IDLE;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; everything is driven from registered state so the
  // outputs hold naturally while the consumer stalls.
  always_comb begin
    arr_start = 1'b0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_err     = 1'b0;
    m_last    = 1'b0;

    if (state_q == S_FIRE) arr_start = 1'b1;

    if (state_q == S_DRAIN) begin
      m_valid = 1'b1;
      m_data  = sel_out;
      m_err   = (reenc != {1'b0, sel_in});
      m_last  = (idx_q == nvalid_q - CW'(1));
    end
  end

  // Saturating error counter, only cleared by reset.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (xfer && m_err && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      nvalid_q  <= '0;
      idx_q     <= '0;
      wait_q    <= '0;
      arr_in_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nvalid_q  <= nvalid_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      arr_in_q  <= arr_in_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign arr_in  = arr_in_q;
  assign err_cnt = err_cnt_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_an37_sys_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_an37_sys_frame_sched
//
// Directed bench for the AN-code frame scheduler. A small behavioural model
// of the decoder array (divide by 37, two-stage pipeline) sits on arr_in /
// arr_out; expected decoded words and error flags are written by hand per
// test.
// ---------------------------------------------------------------------------
module tb_an37_sys_frame_sched;

  localparam int N_WORDS = 36;
  localparam int IN_W    = 18;
  localparam int OUT_W   = 13;

  logic                     clk;
  logic                     rst_n;
  logic                     s_valid;
  logic                     s_ready;
  logic [IN_W-1:0]          s_data;
  logic                     s_last;
  logic [N_WORDS*IN_W-1:0]  arr_in;
  logic                     arr_start;
  logic [N_WORDS*OUT_W-1:0] arr_out;
  logic                     m_valid;
  logic                     m_ready;
  logic [OUT_W-1:0]         m_data;
  logic                     m_err;
  logic                     m_last;
  logic [15:0]              err_cnt;
  logic                     busy;

  int errors = 0;
  int checks = 0;

  logic [IN_W-1:0]  inData  [N_WORDS];
  logic [OUT_W-1:0] expData [N_WORDS];
  bit               expErr  [N_WORDS];

  an37_sys_frame_sched #(
    .N_WORDS(N_WORDS), .IN_W(IN_W), .OUT_W(OUT_W), .A(37), .ARR_LAT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .arr_in(arr_in), .arr_start(arr_start), .arr_out(arr_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err),
    .m_last(m_last), .err_cnt(err_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: floor divide by 37, two register stages (ARR_LAT = 2).
  logic [N_WORDS*OUT_W-1:0] stage1, stage2;
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_WORDS; i++)
      stage1[i*OUT_W +: OUT_W] <= OUT_W'(arr_in[i*IN_W +: IN_W] / 18'd37);
    stage2 <= stage1;
  end
  assign arr_out = stage2;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Offer one word at a negedge and hold it across the accepting posedge.
  task automatic applyStimulus(input logic [IN_W-1:0] d, input bit last);
    int t = 0;
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) checkOutput("s_ready_timeout", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic sendFrame(input int n, input bit useLast);
    for (int k = 0; k < n; k++) applyStimulus(inData[k], useLast && (k == n - 1));
  endtask

  // Consume n words, optionally toggling m_ready; values are checked on
  // stalled cycles as well so holding behaviour is covered.
  task automatic drainFrame(input int n, input bit toggle);
    int  k = 0;
    int  guard = 0;
    bit  phase = 1'b1;
    while (k < n && guard < 500) begin
      m_ready = toggle ? phase : 1'b1;
      phase   = ~phase;
      if (m_valid) begin
        checkOutput("m_data", 32'(m_data), 32'(expData[k]));
        checkOutput("m_err",  32'(m_err),  32'(expErr[k]));
        checkOutput("m_last", 32'(m_last), 32'(k == n - 1));
        if (m_ready) k++;
      end
      @(negedge clk);
      guard++;
    end
    if (k < n) checkOutput("drain_timeout", 32'(k), 32'(n));
    m_ready = 1'b1;
    checkOutput("post_drain_m_valid", 32'(m_valid), 32'd0);
    checkOutput("post_drain_busy",    32'(busy),    32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rst_s_ready",   32'(s_ready),   32'd1);
    checkOutput("rst_arr_start", 32'(arr_start), 32'd0);
    checkOutput("rst_m_valid",   32'(m_valid),   32'd0);
    checkOutput("rst_err_cnt",   32'(err_cnt),   32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: full frame closed by slot 35
    for (int k = 0; k < N_WORDS; k++) begin
      inData[k]  = IN_W'(k * 37);
      expData[k] = OUT_W'(k);
      expErr[k]  = 1'b0;
    end
    sendFrame(N_WORDS, 1'b0);
    checkOutput("t1_s_ready_closed", 32'(s_ready), 32'd0);
    drainFrame(N_WORDS, 1'b0);
    checkOutput("t1_err_cnt", 32'(err_cnt), 32'd0);

    // T2: short frame via s_last, latency and arr_start pulse
    inData[0] = 18'd37;  expData[0] = 13'd1; expErr[0] = 1'b0;
    inData[1] = 18'd74;  expData[1] = 13'd2; expErr[1] = 1'b0;
    inData[2] = 18'd111; expData[2] = 13'd3; expErr[2] = 1'b0;
    sendFrame(3, 1'b1);
    checkOutput("t2_arr_start_fire", 32'(arr_start), 32'd1);
    checkOutput("t2_m_valid_fire",   32'(m_valid),   32'd0);
    checkOutput("t2_pad_slot3",      32'(arr_in[3*IN_W +: IN_W]), 32'd0);
    @(negedge clk);
    checkOutput("t2_arr_start_wait", 32'(arr_start), 32'd0);
    checkOutput("t2_m_valid_wait",   32'(m_valid),   32'd0);
    drainFrame(3, 1'b0);

    // T3: slot 5 carries an invalid codeword
    for (int k = 0; k < N_WORDS; k++) begin
      inData[k]  = IN_W'(k * 37);
      expData[k] = OUT_W'(k);
      expErr[k]  = 1'b0;
    end
    inData[5] = 18'd38; expData[5] = 13'd1; expErr[5] = 1'b1;
    sendFrame(N_WORDS, 1'b0);
    drainFrame(N_WORDS, 1'b0);
    checkOutput("t3_err_cnt", 32'(err_cnt), 32'd1);

    // T4: consumer back-pressure during drain
    for (int k = 0; k < 12; k++) begin
      inData[k]  = IN_W'((100 + k) * 37);
      expData[k] = OUT_W'(100 + k);
      expErr[k]  = 1'b0;
    end
    sendFrame(12, 1'b1);
    drainFrame(12, 1'b1);
    checkOutput("t4_err_cnt", 32'(err_cnt), 32'd1);

    // T5: reset while waiting on the array
    for (int k = 0; k < 4; k++) inData[k] = IN_W'((k + 1) * 37);
    sendFrame(4, 1'b1);
    @(negedge clk);
    checkOutput("t5_busy_wait", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_s_ready",   32'(s_ready),   32'd1);
    checkOutput("t5_rst_arr_start", 32'(arr_start), 32'd0);
    checkOutput("t5_rst_m_valid",   32'(m_valid),   32'd0);
    checkOutput("t5_rst_m_data",    32'(m_data),    32'd0);
    checkOutput("t5_rst_m_err",     32'(m_err),     32'd0);
    checkOutput("t5_rst_m_last",    32'(m_last),    32'd0);
    checkOutput("t5_rst_err_cnt",   32'(err_cnt),   32'd0);
    checkOutput("t5_rst_busy",      32'(busy),      32'd0);
    checkOutput("t5_rst_arr_in",    32'(|arr_in),   32'd0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("t5_no_output", 32'(m_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t5_no_output_after", 32'(m_valid), 32'd0);
    inData[0] = 18'd851; expData[0] = 13'd23; expErr[0] = 1'b0;
    sendFrame(1, 1'b1);
    drainFrame(1, 1'b0);

    // T6: error counter saturation
    force dut.err_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.err_cnt_q;
    @(negedge clk);
    checkOutput("t6_preset", 32'(err_cnt), 32'hFFFE);
    inData[0] = 18'd38;  expData[0] = 13'd1; expErr[0] = 1'b1;
    inData[1] = 18'd75;  expData[1] = 13'd2; expErr[1] = 1'b1;
    inData[2] = 18'd112; expData[2] = 13'd3; expErr[2] = 1'b1;
    sendFrame(3, 1'b1);
    drainFrame(3, 1'b0);
    checkOutput("t6_saturated", 32'(err_cnt), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
